spi_flash_model: RTL and testbench

Synthesizable SPI NOR-flash slave that answers the READ (0x03) command issued by the APB-to-SPI XIP bridge, sitting directly downstream of that bridge on `spi_sck`/`spi_ss[0]`/`spi_mosi`/`spi_miso`. It deserializes command and 24-bit address, fetches 32-bit words from a backing memory over a req/ack port, and shifts the data back MSB-first per byte in SPI mode 0. It runs in the system clock domain and oversamples the SPI pins.

---
 rtl/spi_flash_model.sv | 187 ++++++++++++++++++
 tb/tb_spi_flash_model.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_model.sv
// SPI NOR-flash READ (0x03) slave, mode 0, oversampled in the clock domain.
// Streams little-endian memory words MSB-first per byte with one-word prefetch.
module spi_flash_model #(
  parameter int ADDR_W   = 24,
  parameter int MIN_HALF = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sck,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              underrun
);

  // at short half-periods an ack can land on the same cycle as the fall
  localparam bit ACK_BYPASS = (MIN_HALF < 4);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, FETCH, DATA, IGNORE
  } state_t;

  state_t state, state_nx;

  logic sck_q, sck_qq, ss_q, ss_qq, mosi_q;
  logic rise, fall, ss_fall, ss_rise;
  logic [4:0] cnt;
  logic [22:0] sh_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0] word, src;
  logic word_valid, drop, hole;
  logic [1:0] ptr;
  logic [2:0] bitn;
  logic [7:0] shreg, cur_byte;
  logic cmd_done, cmd_ok, addr_done;
  logic streaming, take_ack, data_fall;
  logic avail, last_byte;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_q  <= 1'b0;
      sck_qq <= 1'b0;
      ss_q   <= 1'b1;
      ss_qq  <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      sck_q  <= sck;
      sck_qq <= sck_q;
      ss_q   <= ss_n;
      ss_qq  <= ss_q;
      mosi_q <= mosi;
    end
  end

  assign rise    = sck_q & ~sck_qq;
  assign fall    = ~sck_q & sck_qq;
  assign ss_fall = ~ss_q & ss_qq;
  assign ss_rise = ss_q & ~ss_qq;

  assign cmd_ok    = ({sh_in[6:0], mosi_q} == 8'h03);
  assign cmd_done  = (state == CMD) & rise
                   & (cnt == 5'd7) & ~ss_rise;
  assign addr_done = (state == ADDR) & rise
                   & (cnt == 5'd23) & ~ss_rise;
  assign addr_in   = ADDR_W'({sh_in, mosi_q});

  assign streaming = (state == FETCH)
                   | (state == DATA);
  assign take_ack  = streaming & mem_req & mem_ack
                   & ~drop & ~ss_rise;
  assign data_fall = streaming & fall & ~ss_rise;

  assign avail     = word_valid | (ACK_BYPASS & take_ack);
  assign src       = word_valid ? word : mem_rdata;
  assign cur_byte  = src[{ptr, 3'b000} +: 8];
  assign last_byte = (ptr == 2'd3);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    if (ss_rise) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (ss_fall) state_nx = CMD;
        CMD:     if (cmd_done)
                   state_nx = cmd_ok ? ADDR : IGNORE;
        ADDR:    if (addr_done) state_nx = FETCH;
        FETCH:   if (take_ack) state_nx = DATA;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      sh_in      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      drop       <= 1'b0;
      hole       <= 1'b0;
      ptr        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      miso       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (drop & mem_ack) begin
        drop    <= 1'b0;
        mem_req <= 1'b0;
      end
      if (ss_rise) begin
        miso       <= 1'b0;
        word_valid <= 1'b0;
        hole       <= 1'b0;
        // an abandoned fetch must still complete on the memory side
        if (mem_req & ~drop) begin
          if (mem_ack) mem_req <= 1'b0;
          else         drop    <= 1'b1;
        end
      end else begin
        if ((state == IDLE) && ss_fall)
          cnt <= '0;
        if (((state == CMD) || (state == ADDR)) && rise) begin
          sh_in <= {sh_in[21:0], mosi_q};
          cnt   <= cmd_done ? 5'd0 : cnt + 5'd1;
        end
        if (addr_done) begin
          mem_addr   <= {addr_in[ADDR_W-1:2], 2'b00};
          ptr        <= addr_in[1:0];
          mem_req    <= 1'b1;
          bitn       <= '0;
          hole       <= 1'b0;
          word_valid <= 1'b0;
        end
        if (take_ack) begin
          word       <= mem_rdata;
          word_valid <= 1'b1;
          mem_req    <= 1'b0;
        end
        if (data_fall) begin
          bitn <= bitn + 3'd1;
          if (bitn == 3'd0) begin
            if (avail) begin
              miso  <= cur_byte[7];
              shreg <= {cur_byte[6:0], 1'b0};
              hole  <= 1'b0;
              if (last_byte) begin
                ptr        <= 2'd0;
                word_valid <= 1'b0;
                mem_req    <= 1'b1;
                mem_addr   <= mem_addr + ADDR_W'(4);
              end else begin
                ptr <= ptr + 2'd1;
              end
            end else begin
              hole     <= 1'b1;
              miso     <= 1'b0;
              underrun <= 1'b1;
            end
          end else if (hole) begin
            miso     <= 1'b0;
            underrun <= 1'b1;
          end else begin
            miso  <= shreg[7];
            shreg <= {shreg[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_model.sv
// Bench for spi_flash_model: SPI master, req/ack memory and a byte-stream
// reference model of the READ command.
module tb_spi_flash_model;

  logic        clock = 1'b0;
  logic        reset, sck, ss_n, mosi;
  logic        miso, mem_req, mem_ack;
  logic        busy, underrun;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;

  always #5 clock = ~clock;

  spi_flash_model dut (
    .clock     (clock),
    .reset     (reset),
    .sck       (sck),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .underrun  (underrun)
  );

  int n_chk = 0;
  int n_pass = 0;
  int h_cur = 5;
  int lat = 1;
  bit ur_acc;
  int ur_total, pre_nz, busy_lat;

  logic [7:0]  ovr [int];
  logic [23:0] fetch_q [$];
  logic [7:0]  rx_q [$];
  bit          hole_q [$];

  function automatic logic [7:0] byte_at(input int unsigned a);
    int unsigned k;
    logic [31:0] x;
    k = a & 32'hFFFFFF;
    if (ovr.exists(int'(k))) return ovr[int'(k)];
    x = k * 32'h9E3779B1;
    x = x ^ (x >> 15);
    return x[7:0];
  endfunction

  function automatic logic [31:0] word_at(input int unsigned a);
    return {byte_at(a + 3), byte_at(a + 2),
            byte_at(a + 1), byte_at(a)};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // memory side: ack each request after lat cycles
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req === 1'b1) begin
        repeat (lat) @(negedge clock);
        mem_rdata = word_at(int'(mem_addr));
        mem_ack   = 1'b1;
        fetch_q.push_back(mem_addr);
        @(negedge clock);
        mem_ack = 1'b0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clock);
      if (underrun === 1'b1) begin
        ur_acc = 1'b1;
        ur_total++;
      end
    end
  endtask

  task automatic send_bit(input logic b,
                          output logic s,
                          output bit u);
    mosi   = b;
    ur_acc = 1'b0;
    wait_cyc(h_cur);
    s   = miso;
    u   = ur_acc;
    sck = 1'b1;
    wait_cyc(h_cur);
    sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] cmd,
                      input logic [23:0] a,
                      input int abits,
                      input int nbytes);
    logic s;
    bit u, hb;
    logic [7:0] b;
    int n;
    rx_q.delete();
    hole_q.delete();
    fetch_q.delete();
    pre_nz   = 0;
    ur_total = 0;
    ss_n = 1'b0;
    wait_cyc(h_cur);
    for (int i = 0; i < 8; i++) begin
      send_bit(cmd[7-i], s, u);
      if (s !== 1'b0) pre_nz++;
    end
    for (int i = 0; i < abits; i++) begin
      send_bit(a[23-i], s, u);
      if (s !== 1'b0) pre_nz++;
    end
    for (int k = 0; k < nbytes; k++) begin
      b  = '0;
      hb = 1'b0;
      for (int j = 0; j < 8; j++) begin
        send_bit(1'($urandom), s, u);
        if (j == 0) hb = u;
        b = {b[6:0], s};
      end
      rx_q.push_back(b);
      hole_q.push_back(hb);
    end
    wait_cyc(h_cur);
    ss_n = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      wait_cyc(1);
      n++;
    end
    busy_lat = n;
    wait_cyc(lat + 12);
  endtask

  task automatic run_read(input string tag,
                          input logic [23:0] a,
                          input int n,
                          input bit late);
    int holes, di, nf, len;
    logic [23:0] base, exp_a;
    xfer(8'h03, a, 24, n);
    holes = 0;
    di    = 0;
    for (int k = 0; k < n; k++) begin
      if (hole_q[k]) begin
        holes++;
        check($sformatf("%s hole%0d", tag, k), 32'(rx_q[k]), 0);
      end else begin
        check($sformatf("%s byte%0d", tag, k), 32'(rx_q[k]),
              32'(byte_at(int'(a) + di)));
        di++;
      end
    end
    if (late) check({tag, " underrun"}, 32'(ur_total > 0), 1);
    else      check({tag, " underrun"}, ur_total, 0);
    len = n + 1 - holes;
    nf  = 1;
    for (int k = 0; k < len; k++)
      if (((int'(a) + k) & 3) == 3) nf++;
    check({tag, " fetches"}, fetch_q.size(), nf);
    base = a & 24'hFFFFFC;
    for (int i = 0; i < nf && i < fetch_q.size(); i++) begin
      exp_a = base + 24'(4 * i);
      check($sformatf("%s faddr%0d", tag, i),
            32'(fetch_q[i]), 32'(exp_a));
    end
    check({tag, " pre miso"}, pre_nz, 0);
    check({tag, " busy drop"},
          32'(busy_lat >= 1 && busy_lat <= 3), 1);
  endtask

  initial begin
    logic [7:0] acc;
    logic s;
    bit u;
    logic [17:0] part;
    reset = 1'b1;
    sck   = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    ovr[32'h100] = 8'hAA; ovr[32'h101] = 8'hBB;
    ovr[32'h102] = 8'hCC; ovr[32'h103] = 8'hDD;
    ovr[32'h104] = 8'h11; ovr[32'h105] = 8'h22;
    ovr[32'h106] = 8'h33; ovr[32'h107] = 8'h44;
    repeat (3) @(negedge clock);
    check("rst miso", 32'(miso), 0);
    check("rst mem_req", 32'(mem_req), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst busy", 32'(busy), 0);
    check("rst underrun", 32'(underrun), 0);
    reset = 1'b0;
    wait_cyc(3);

    h_cur = 5;
    lat   = 1;
    run_read("one word", 24'h000100, 4, 0);
    run_read("two words", 24'h000100, 8, 0);
    run_read("unaligned", 24'h000102, 4, 0);
    run_read("wrap", 24'hFFFFFC, 8, 0);

    xfer(8'h9F, 24'h123456, 24, 4);
    acc = '0;
    foreach (rx_q[k]) acc = acc | rx_q[k];
    check("ignore miso", 32'(acc), 0);
    check("ignore pre miso", pre_nz, 0);
    check("ignore no req", fetch_q.size(), 0);
    check("ignore underrun", ur_total, 0);
    check("ignore busy drop",
          32'(busy_lat >= 1 && busy_lat <= 3), 1);

    xfer(8'h03, 24'h000040, 20, 0);
    check("abort no req", fetch_q.size(), 0);
    check("abort busy drop",
          32'(busy_lat >= 1 && busy_lat <= 3), 1);
    run_read("after abort", 24'h000000, 4, 0);

    part = {8'h03, 10'h155};
    ss_n = 1'b0;
    wait_cyc(h_cur);
    for (int i = 0; i < 18; i++) send_bit(part[17-i], s, u);
    reset = 1'b1;
    #1;
    check("mid reset busy", 32'(busy), 0);
    check("mid reset req", 32'(mem_req), 0);
    ss_n = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(3);
    run_read("after reset", 24'h000104, 4, 0);

    for (int r = 0; r < 6; r++) begin
      h_cur = $urandom_range(7, 4);
      lat   = $urandom_range(2, 0);
      run_read($sformatf("rnd%0d", r), 24'($urandom),
               $urandom_range(10, 1), 0);
    end

    h_cur = 6;
    lat   = 40;
    run_read("late ack", 24'h000200, 8, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
